// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC, credit-limited imem requests, response FIFO, redirect flush
//
// Ports:
//   clock, reset_n                   rising-edge clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      load a new fetch PC (low two bits forced to zero)
//   imem_req_valid/ready/addr        word-aligned request channel to instruction memory
//   imem_resp_valid/data             in-order response words, no backpressure
//   instr_valid/ready                handshake towards decode
//   instruction, instr_pc            head instruction word and its PC
//
// Optional feature (macro FETCH_BYPASS_EN): when the FIFO is empty, no flush is
// pending and no redirect is present, a response word is presented to decode in
// the same cycle it arrives; it is written to the FIFO only if decode stalls.
module fetch #(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] instr_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_count_q, drop_count_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [WORD_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_data_d [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_pc_d   [FIFO_DEPTH];

  logic                 fifo_empty;
  logic                 credit_ok;
  logic                 req_fire;
  logic                 bypass;
  logic                 consume_bypass;
  logic                 pop;
  logic                 push;
  logic [WORD_SIZE-1:0] redirect_target;

  assign fifo_empty      = (count_q == '0);
  assign redirect_target = redirect_pc & ~WORD_SIZE'(3);

  // Every issued request owns a FIFO slot until it is popped or flushed, so
  // a response can always be pushed without checking for space.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);

  // reset_n gates the combinational outputs so they drop as soon as reset asserts.
  assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass = reset_n && fifo_empty && (state_q == ST_RUN) && !redirect_valid && imem_resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid    = reset_n && !redirect_valid && (!fifo_empty || bypass);
  assign instruction    = bypass ? imem_resp_data : fifo_data_q[rd_ptr_q];
  assign instr_pc       = bypass ? resp_pc_q      : fifo_pc_q[rd_ptr_q];
  assign consume_bypass = bypass && instr_ready;
  assign pop            = instr_valid && instr_ready && !fifo_empty;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_count_d  = drop_count_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;
    push          = 1'b0;

    if (redirect_valid) begin
      // No request can fire this cycle, so only an arriving response changes
      // the in-flight count; everything still in flight afterwards is stale.
      fetch_pc_d    = redirect_target;
      resp_pc_d     = redirect_target;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(imem_resp_valid);
      drop_count_d  = outstanding_d;
      state_d       = (outstanding_d != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

      if (imem_resp_valid) begin
        if (state_q == ST_FLUSH) begin
          drop_count_d = drop_count_q - CW'(1);
          if (drop_count_q == CW'(1)) begin
            state_d = ST_RUN;
          end
        end else begin
          resp_pc_d = resp_pc_q + WORD_SIZE'(4);
          push      = !consume_bypass;
        end
      end

      if (push) begin
        fifo_data_d[wr_ptr_q] = imem_resp_data;
        fifo_pc_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_count_q  <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_data_q   <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_data_q   <= fifo_data_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized scoreboard bench for the fetch stage
module tb_fetch;
  localparam int          WS    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clock;
  logic          reset_n;
  logic          redirect_valid;
  logic [WS-1:0] redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [WS-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [WS-1:0] imem_resp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [WS-1:0] instruction;
  logic [WS-1:0] instr_pc;

  fetch #(.WORD_SIZE(WS), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] exp_req_pc;
  int          tests     = 0;
  int          fails     = 0;
  int          cyc       = 0;
  int          delivered = 0;
  bit          mon_en    = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode-side monitor: every consumed instruction must be the next entry
  // of the reference stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (mon_en && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got pc %h, expected none (cycle %0d)", instr_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instruction", instruction, e.data);
          delivered++;
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    instr_ready     = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    pend_q.delete();
    exp_req_pc = RPC;
  endtask

  // One cycle of randomized memory/decode/redirect stimulus.
  task automatic drive_cycle(input bit allow_redirect, input bit stall, input bit allow_req);
    logic [31:0] tgt;
    pend_t       p;
    @(negedge clock);
    cyc++;
    if (allow_redirect && $urandom_range(0, 15) == 0) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
      else                           tgt = $urandom & 32'h0000_0FFF;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      exp_q.delete();
      exp_req_pc = tgt & ~32'd3;
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    instr_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (pend_q.size() > 0 && pend_q[0].rdy <= cyc && $urandom_range(0, 3) != 0) begin
      p = pend_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(p.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = allow_req && ($urandom_range(0, 3) != 0);
    #2;
    if (redirect_valid) check("req_during_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (!redirect_valid && exp_q.size() >= DEPTH)
      check("req_when_full", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_pc);
      pend_q.push_back('{addr: imem_req_addr, rdy: cyc + 1});
      exp_q.push_back('{pc: exp_req_pc, data: mem_word(exp_req_pc)});
      exp_req_pc = exp_req_pc + 32'd4;
      tests++;
      if (exp_q.size() > DEPTH) begin
        fails++;
        $display("FAIL credit_cap: got %0d words in flight expected <= %0d", exp_q.size(), DEPTH);
      end
    end
  endtask

  initial begin
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    instr_ready     = 1'b0;
    exp_req_pc      = RPC;
    do_reset();

    // Directed: first request and response-to-decode latency.
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #2;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, RPC);
    @(negedge clock);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0050_0093;
    #2;
`ifdef FETCH_BYPASS_EN
    check("bypass_valid", {31'b0, instr_valid}, 32'd1);
    check("bypass_instr", instruction, 32'h0050_0093);
    check("bypass_pc", instr_pc, RPC);
`else
    check("lat_n_valid", {31'b0, instr_valid}, 32'd0);
`endif
    @(negedge clock);
    imem_resp_valid = 1'b0;
    #2;
`ifdef FETCH_BYPASS_EN
    check("bypass_fifo_empty", {31'b0, instr_valid}, 32'd0);
`else
    check("lat_n1_valid", {31'b0, instr_valid}, 32'd1);
    check("lat_n1_instr", instruction, 32'h0050_0093);
    check("lat_n1_pc", instr_pc, RPC);
`endif
    @(negedge clock);
    #2;
    check("after_pop_valid", {31'b0, instr_valid}, 32'd0);
    check("next_req_addr", imem_req_addr, RPC + 32'd4);
    exp_req_pc = RPC + 32'd4;

    // Randomized traffic with a forced decode stall window and a mid-stream reset.
    mon_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2;
        do_reset();
      end
      drive_cycle(!(n >= 200 && n < 215), (n >= 200 && n < 215), 1'b1);
    end

    // Drain: no new requests; everything in flight must reach decode.
    for (int n = 0; n < 200 && (pend_q.size() > 0 || exp_q.size() > 0); n++)
      drive_cycle(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #4;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    tests++;
    if (delivered < 200) begin
      fails++;
      $display("FAIL progress: got %0d delivered expected >= 200", delivered);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
